// File: rtl/cntr_bs_pkg.sv
// Shared types and sizing helpers for the bank-scheduler control block.
package cntr_bs_pkg;

  typedef enum logic {
    BS_WRITE = 1'b0,
    BS_READ  = 1'b1
  } bs_mode_t;

  localparam logic TYPE_READ  = 1'b1;
  localparam logic TYPE_WRITE = 1'b0;

  function automatic int unsigned fifo_num(input int unsigned rd, input int unsigned wr);
    return rd + wr;
  endfunction

  function automatic int unsigned ra_all(input int unsigned ra, input int unsigned n);
    return ra * n;
  endfunction

endpackage

// File: rtl/cntr_bs_rr_pick.sv
// Round-robin one-hot picker: first requester strictly after i_last, wrapping around.
module cntr_bs_rr_pick #(
  parameter int unsigned  N  = 7,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_j     = '0;
    // k == N lands back on i_last, so the previous owner is considered last
    for (int k = 1; k <= int'(N); k++) begin
      w_j = IW'((int'(i_last) + k) % int'(N));
      if (!o_found && i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
    if (o_found) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cntr_bs_sched.sv
// Bank-scheduler control: row-hit entry steering and read/write exit arbitration.
// Optional write-starvation guard enabled by defining BS_STARVE_EN.
module cntr_bs_sched
  import cntr_bs_pkg::*;
#(
  parameter int unsigned  RD_FIFO_NUM  = 4,
  parameter int unsigned  WR_FIFO_NUM  = 3,
  parameter int unsigned  RA           = 16,
  parameter int unsigned  MAX_BURST    = 4,
  parameter int unsigned  STARVE_LIMIT = 32,
  localparam int unsigned FIFO_NUM     = fifo_num(RD_FIFO_NUM, WR_FIFO_NUM),
  localparam int unsigned RA_ALL       = ra_all(RA, FIFO_NUM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_type,
  input  logic [RA-1:0]       in_ra,
  output logic                in_ready,
  output logic [FIFO_NUM-1:0] push,
  input  logic [FIFO_NUM-1:0] full,
  input  logic [FIFO_NUM-1:0] mid,
  input  logic [FIFO_NUM-1:0] valid,
  input  logic [RA_ALL-1:0]   last_ra,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [FIFO_NUM-1:0] pop,
  output logic                mode_o
);

  localparam int unsigned SW = (FIFO_NUM > 1) ? $clog2(FIFO_NUM) : 1;
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [FIFO_NUM-1:0] RdMask = {{WR_FIFO_NUM{1'b0}}, {RD_FIFO_NUM{1'b1}}};
  localparam logic [FIFO_NUM-1:0] WrMask = ~RdMask;
  localparam logic [BW-1:0] BurstMax = BW'(MAX_BURST);

  // Entry steering
  logic [FIFO_NUM-1:0] w_cand;
  logic [FIFO_NUM-1:0] w_hit;
  logic [FIFO_NUM-1:0] w_emp;
  logic [FIFO_NUM-1:0] w_ent_vec;
  logic [FIFO_NUM-1:0] w_ent_oh;

  always_comb begin
    w_cand = (in_type == TYPE_READ) ? RdMask : WrMask;
    w_hit  = '0;
    for (int g = 0; g < int'(FIFO_NUM); g++) begin
      w_hit[g] = w_cand[g] & valid[g] & ~full[g] & (last_ra[g*RA +: RA] == in_ra);
    end
    w_emp     = w_cand & ~valid;
    w_ent_vec = (|w_hit) ? w_hit : w_emp;
    // Isolate lowest set bit
    w_ent_oh  = w_ent_vec & (~w_ent_vec + FIFO_NUM'(1));
  end

  assign in_ready = |w_ent_oh;
  assign push     = w_ent_oh & {FIFO_NUM{in_valid}};

  // Exit arbitration
  bs_mode_t            r_mode;
  logic [SW-1:0]       r_sel;
  logic [FIFO_NUM-1:0] r_sel_oh;
  logic                r_sel_vld;
  logic [BW-1:0]       r_burst;

  logic                w_rd_any;
  logic                w_wr_any;
  logic                w_wr_press;
  logic                w_wr_mid;
  logic                w_starve_force;
  logic                w_mode_chg;
  logic                w_resel;
  logic                w_fire;
  logic [FIFO_NUM-1:0] w_pick_req;
  logic [FIFO_NUM-1:0] w_pick_gnt;
  logic [SW-1:0]       w_pick_idx;
  logic                w_pick_found;

  assign w_rd_any   = |(valid & RdMask);
  assign w_wr_any   = |(valid & WrMask);
  assign w_wr_press = |((mid | full) & WrMask);
  assign w_wr_mid   = |(mid & WrMask);

  assign w_mode_chg = (r_mode == BS_READ)
                    ? (w_wr_press | (~w_rd_any & w_wr_any) | w_starve_force)
                    : (~w_wr_any | (~w_wr_mid & w_rd_any));

  assign out_valid  = r_sel_vld & |(valid & r_sel_oh);
  assign w_fire     = out_valid & out_ready;
  assign w_resel    = ~out_valid;
  assign pop        = r_sel_oh & {FIFO_NUM{w_fire}};
  assign mode_o     = (r_mode == BS_READ);
  assign w_pick_req = valid & ((r_mode == BS_READ) ? RdMask : WrMask);

  cntr_bs_rr_pick #(
    .N (FIFO_NUM)
  ) u_rr_pick (
    .i_req   (w_pick_req),
    .i_last  (r_sel),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

`ifdef BS_STARVE_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] StarveMax = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve;

  assign w_starve_force = (r_mode == BS_READ) && (r_starve == StarveMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if ((r_mode == BS_READ) && w_wr_any && !w_mode_chg) begin
      if (r_starve != StarveMax) begin
        r_starve <= r_starve + CW'(1);
      end
    end else begin
      r_starve <= '0;
    end
  end
`else
  assign w_starve_force = 1'b0;
`endif

  // Mode change outranks reselect; burst end drops sel_vld so the next cycle reselects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= BS_READ;
      r_sel     <= '0;
      r_sel_oh  <= FIFO_NUM'(1);
      r_sel_vld <= 1'b0;
      r_burst   <= '0;
    end else if (w_mode_chg) begin
      r_mode    <= (r_mode == BS_READ) ? BS_WRITE : BS_READ;
      r_sel_vld <= 1'b0;
      r_burst   <= '0;
    end else if (w_resel) begin
      if (w_pick_found) begin
        r_sel    <= w_pick_idx;
        r_sel_oh <= w_pick_gnt;
      end
      r_sel_vld <= w_pick_found;
      r_burst   <= '0;
    end else if (w_fire) begin
      r_burst <= r_burst + BW'(1);
      if (r_burst + BW'(1) == BurstMax) begin
        r_sel_vld <= 1'b0;
      end
    end
  end

endmodule
